// File: rtl/intersect_frame_scheduler.sv
// intersect_frame_scheduler: issues one frame of raster-order pixels under credit flow control,
// holding a snapshot of block positions for the whole frame and flagging completion.
module intersect_frame_scheduler #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int CREDITS    = 16,
    parameter int NUM_BLOCKS = 12
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         frame_start_in,
    input  logic [NUM_BLOCKS-1:0][11:0]  block_x_notfloat_in,
    input  logic [NUM_BLOCKS-1:0][11:0]  block_y_notfloat_in,
    input  logic [NUM_BLOCKS-1:0][13:0]  block_z_notfloat_in,
    input  logic                         result_valid_in,
    input  logic                         credit_return_in,
    output logic [10:0]                  x_out,
    output logic [9:0]                   y_out,
    output logic                         valid_out,
    output logic [NUM_BLOCKS-1:0][11:0]  block_x_out,
    output logic [NUM_BLOCKS-1:0][11:0]  block_y_out,
    output logic [NUM_BLOCKS-1:0][13:0]  block_z_out,
    output logic                         busy_out,
    output logic                         frame_done_out,
    output logic                         err_out
);
    localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
    localparam logic [9:0]  Y_LAST = 10'(HEIGHT - 1);
    localparam logic [20:0] TOTAL  = 21'(WIDTH * HEIGHT);
    localparam logic [7:0]  CRED   = 8'(CREDITS);

    typedef enum logic [1:0] {IDLE, LATCH, ISSUE, DRAIN} state_t;

    state_t                        state_q;
    logic [10:0]                   px_q, x_q, cx;
    logic [9:0]                    py_q, y_q, cy;
    logic [7:0]                    credits_q, credits_d;
    logic [20:0]                   res_q, res_d;
    logic                          valid_q, busy_q, done_q, err_q;
    logic                          issue, last, res_en, err_now;
    logic [NUM_BLOCKS-1:0][11:0]   bx_q, by_q;
    logic [NUM_BLOCKS-1:0][13:0]   bz_q;

    // The edge leaving LATCH already issues (0,0), so the first pixel appears right after LATCH.
    always_comb begin
        cx        = state_q == LATCH ? '0 : px_q;
        cy        = state_q == LATCH ? '0 : py_q;
        issue     = (state_q == LATCH || state_q == ISSUE) && credits_q != 8'd0;
        last      = cx == X_LAST && cy == Y_LAST;
        credits_d = issue && !credit_return_in ? credits_q - 8'd1 :
                    !issue && credit_return_in && credits_q != CRED ? credits_q + 8'd1 : credits_q;
        res_en    = result_valid_in && (state_q == ISSUE || state_q == DRAIN);
        res_d     = state_q == LATCH ? '0 : res_q + 21'(res_en);
        err_now   = (credit_return_in && credits_q == CRED && !issue) ||
                    (result_valid_in && (state_q == IDLE || state_q == LATCH)) ||
                    (res_en && res_q == TOTAL);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            px_q      <= '0;
            py_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            credits_q <= CRED;
            res_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bx_q      <= '0;
            by_q      <= '0;
            bz_q      <= '0;
        end else begin
            credits_q <= credits_d;
            res_q     <= res_d;
            err_q     <= err_q | err_now;
            valid_q   <= issue;
            done_q    <= 1'b0;
            if (issue) begin
                x_q  <= cx;
                y_q  <= cy;
                px_q <= cx == X_LAST ? 11'd0 : cx + 11'd1;
                py_q <= cx == X_LAST ? cy + 10'd1 : cy;
            end
            case (state_q)
                IDLE: if (frame_start_in) begin
                    state_q <= LATCH;
                    busy_q  <= 1'b1;
                end
                LATCH: begin
                    bx_q    <= block_x_notfloat_in;
                    by_q    <= block_y_notfloat_in;
                    bz_q    <= block_z_notfloat_in;
                    state_q <= issue && last ? DRAIN : ISSUE;
                    if (!issue) begin
                        px_q <= '0;
                        py_q <= '0;
                    end
                end
                ISSUE: if (issue && last) state_q <= DRAIN;
                DRAIN: if (res_d == TOTAL) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_out          = x_q;
    assign y_out          = y_q;
    assign valid_out      = valid_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;
    assign err_out        = err_q;
    assign block_x_out    = bx_q;
    assign block_y_out    = by_q;
    assign block_z_out    = bz_q;
endmodule

// File: tb/tb_intersect_frame_scheduler.sv
// tb_intersect_frame_scheduler: directed and randomized frames checked against a
// count-based model of pixels issued, credits held and results returned.
module tb_intersect_frame_scheduler;
    localparam int W = 4, H = 2, C = 3, NB = 12, TOTAL = W * H;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic start = 1'b0, ret = 1'b0, rv = 1'b0;
    logic [NB-1:0][11:0] bx_in = '0, by_in = '0;
    logic [NB-1:0][13:0] bz_in = '0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic valid_out, busy_out, frame_done_out, err_out;
    logic [NB-1:0][11:0] bx_out, by_out;
    logic [NB-1:0][13:0] bz_out;

    intersect_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .CREDITS(C), .NUM_BLOCKS(NB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(start),
        .block_x_notfloat_in(bx_in), .block_y_notfloat_in(by_in), .block_z_notfloat_in(bz_in),
        .result_valid_in(rv), .credit_return_in(ret),
        .x_out(x_out), .y_out(y_out), .valid_out(valid_out),
        .block_x_out(bx_out), .block_y_out(by_out), .block_z_out(bz_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0, bad = 0, done_seen = 0;
    // model: mm 0=idle 1=latch 2=frame active; counts of pixels issued and results received
    int mm = 0, mcred = C, issued = 0, results = 0;
    logic [10:0] ex = '0;
    logic [9:0]  ey = '0;
    logic ev = 0, ebusy = 0, edone = 0, eerr = 0;
    logic [NB-1:0][11:0] ebx = '0, eby = '0;
    logic [NB-1:0][13:0] ebz = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("x", 256'(x_out), 256'(ex));
        chk("y", 256'(y_out), 256'(ey));
        chk("valid", 256'(valid_out), 256'(ev));
        chk("busy", 256'(busy_out), 256'(ebusy));
        chk("done", 256'(frame_done_out), 256'(edone));
        chk("err", 256'(err_out), 256'(eerr));
        chk("blk_x", 256'(bx_out), 256'(ebx));
        chk("blk_y", 256'(by_out), 256'(eby));
        chk("blk_z", 256'(bz_out), 256'(ebz));
        if (frame_done_out === 1'b1) done_seen++;
    endtask

    task automatic model_reset();
        mm = 0; mcred = C; issued = 0; results = 0;
        ex = '0; ey = '0; ev = 0; ebusy = 0; edone = 0; eerr = 0;
        ebx = '0; eby = '0; ebz = '0;
    endtask

    task automatic model_edge();
        int iss;
        edone = 0;
        iss = (((mm == 1) || (mm == 2 && issued < TOTAL)) && mcred > 0) ? 1 : 0;
        if (ret && mcred == C && iss == 0) eerr = 1;
        if (rv && mm < 2) eerr = 1;
        if (rv && mm == 2 && results == TOTAL) eerr = 1;
        ev = (iss == 1);
        if (iss == 1) begin
            ex = 11'(issued % W);
            ey = 10'(issued / W);
            issued++;
        end
        mcred = mcred + int'(ret) - iss;
        if (mcred > C) mcred = C;
        if (mm == 2 && rv) results++;
        if (mm == 0) begin
            if (start) begin
                mm = 1; ebusy = 1; issued = 0; results = 0;
            end
        end else if (mm == 1) begin
            mm = 2; ebx = bx_in; eby = by_in; ebz = bz_in;
        end else if (issued == TOTAL && results == TOTAL) begin
            mm = 0; ebusy = 0; edone = 1;
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        chk_all();
    endtask

    task automatic cyc(input logic s, input logic r, input logic v);
        start = s; ret = r; rv = v;
        step();
    endtask

    task automatic drive_auto(input int rp, input int vp);
        start = 1'b0;
        ret = (mcred < C) && ($urandom_range(99) < rp);
        rv = (mm == 2) && (issued - results > 0) && ($urandom_range(99) < vp);
        step();
    endtask

    task automatic run_frame(input int rp, input int vp);
        for (int i = 0; i < 400 && mm != 0; i++) drive_auto(rp, vp);
        chk("frame_timeout", 256'(mm), 256'(0));
        start = 0; ret = 0; rv = 0;
    endtask

    task automatic rand_blocks();
        for (int i = 0; i < NB; i++) begin
            bx_in[i] = 12'($urandom);
            by_in[i] = 12'($urandom);
            bz_in[i] = 14'($urandom);
        end
    endtask

    task automatic async_reset();
        #2 rst_in = 1'b0;
        start = 0; ret = 0; rv = 0;
        #1;
        model_reset();
        chk_all();
        @(negedge clk_in) rst_in = 1'b1;
    endtask

    initial begin
        int nv;
        #2 rst_in = 1'b0;
        @(negedge clk_in);
        chk_all();
        rst_in = 1'b1;

        // basic frame, credits returned as soon as any are outstanding
        rand_blocks();
        done_seen = 0;
        cyc(1, 0, 0);
        run_frame(100, 100);
        chk("basic_done_count", 256'(done_seen), 256'(1));
        step();

        // credit stall with no returns
        rand_blocks();
        bx_in[0] = 12'd5;
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        chk("stall_x", 256'(x_out), 256'(2));
        chk("stall_valid", 256'(valid_out), 256'(0));
        nv = 0;
        cyc(0, 1, 0);
        nv += int'(valid_out);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            nv += int'(valid_out);
        end
        chk("one_more_issue", 256'(nv), 256'(1));
        chk("after_return_x", 256'(x_out), 256'(3));
        bx_in[0] = 12'd9;
        cyc(0, 0, 0);
        chk("snapshot_hold", 256'(bx_out[0]), 256'(5));
        run_frame(60, 60);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("snapshot_reload", 256'(bx_out[0]), 256'(9));
        run_frame(100, 100);

        // simultaneous issue and return at one credit
        while (mcred < C) cyc(0, 1, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0);
            nv += int'(valid_out);
        end
        chk("sustained_issue", 256'(nv), 256'(5));
        run_frame(100, 100);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            rand_blocks();
            cyc(1, 0, 0);
            run_frame(int'($urandom_range(20, 100)), int'($urandom_range(20, 100)));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) drive_auto(50, 0);
        end

        // asynchronous reset mid-issue, then a clean frame
        rand_blocks();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        async_reset();
        chk("reset_valid", 256'(valid_out), 256'(0));
        chk("reset_busy", 256'(busy_out), 256'(0));
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("restart_first", 256'({valid_out, x_out, y_out}), 256'({1'b1, 11'd0, 10'd0}));
        run_frame(70, 70);

        // protocol errors
        cyc(0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("err_idle_result", 256'(err_out), 256'(1));
        async_reset();
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("err_extra_credit", 256'(err_out), 256'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
